// File: rtl/jtshouse_mmr_shadow.sv
// rtl/jtshouse_mmr_shadow.sv - memory-mapped register file with frame-synchronous shadow copy and object DMA trigger
module jtshouse_mmr_shadow #(
  parameter int AW      = 4,
  parameter int SHADOW  = 1,
  parameter int DMA_REG = 0
) (
  input  logic                 rst,
  input  logic                 clk,
  input  logic                 cs,
  input  logic                 rnw,
  input  logic [AW-1:0]        addr,
  input  logic [7:0]           din,
  output logic [7:0]           dout,
  input  logic                 lvbl,
  output logic                 dma_req,
  input  logic                 dma_ack,
  output logic                 dma_done,
  output logic [8*(2**AW)-1:0] regs,
  input  logic [AW-1:0]        ioctl_addr,
  output logic [7:0]           ioctl_din,
  input  logic [7:0]           debug_bus,
  output logic [7:0]           st_dout
);

  localparam int SIZE = 2**AW;
  localparam logic [AW-1:0] DMA_IDX = DMA_REG[AW-1:0];

  typedef enum logic [1:0] {IDLE, ARMED, REQ} state_t;

  logic [7:0] stg[SIZE];
  logic [7:0] act[SIZE];
  logic       lvbl_l;
  logic       fs;
  logic       wr;
  logic       dma_wr;
  logic       queued;
  state_t     state;
  logic       unused_dbg;

  assign fs         = lvbl_l & ~lvbl;
  assign wr         = cs & ~rnw;
  assign dma_wr     = wr && (addr == DMA_IDX);
  assign unused_dbg = ^debug_bus;

  always_comb begin
    regs = '0;
    for (int n = 0; n < SIZE; n++) regs[8*n +: 8] = act[n];
  end

  // The frame-start copy reads stg before this cycle's write lands, so a
  // write in the fs cycle only reaches act on the following frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        stg[i] <= 8'h00;
        act[i] <= 8'h00;
      end
    end else begin
      if (SHADOW != 0 && fs) begin
        for (int i = 0; i < SIZE; i++) act[i] <= stg[i];
      end
      if (wr) begin
        stg[addr] <= din;
        if (SHADOW == 0) act[addr] <= din;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout      <= 8'h00;
      ioctl_din <= 8'h00;
      st_dout   <= 8'h00;
      lvbl_l    <= 1'b1;
    end else begin
      dout      <= stg[addr];
      ioctl_din <= stg[ioctl_addr];
      st_dout   <= stg[debug_bus[AW-1:0]];
      lvbl_l    <= lvbl;
    end
  end

  // A DMA_REG write while a request is outstanding is remembered in queued
  // and re-arms the engine once the current transfer is acknowledged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dma_req  <= 1'b0;
      dma_done <= 1'b0;
      queued   <= 1'b0;
    end else begin
      dma_done <= 1'b0;
      case (state)
        IDLE: begin
          if (dma_wr) state <= ARMED;
        end
        ARMED: begin
          if (fs) begin
            state   <= REQ;
            dma_req <= 1'b1;
          end
        end
        REQ: begin
          if (dma_ack) begin
            dma_req  <= 1'b0;
            dma_done <= 1'b1;
            queued   <= 1'b0;
            state    <= (queued || dma_wr) ? ARMED : IDLE;
          end else if (dma_wr) begin
            queued <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtshouse_mmr_shadow.sv
// tb/tb_jtshouse_mmr_shadow.sv - self-checking bench for jtshouse_mmr_shadow
module tb_jtshouse_mmr_shadow;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cs = 1'b0, rnw = 1'b1, lvbl = 1'b1, dma_ack = 1'b0;
  logic [3:0]   addr = '0, ioctl_addr = '0;
  logic [7:0]   din = '0, debug_bus = '0;
  logic [7:0]   dout, ioctl_din, st_dout;
  logic         dma_req, dma_done;
  logic [127:0] regs;

  logic         cs2 = 1'b0, rnw2 = 1'b1, lvbl2 = 1'b1, dma_ack2 = 1'b0;
  logic [5:0]   addr2 = '0, ioctl_addr2 = '0;
  logic [7:0]   din2 = '0, debug_bus2 = '0;
  logic [7:0]   dout2, ioctl_din2, st_dout2;
  logic         dma_req2, dma_done2;
  logic [511:0] regs2;

  int checks = 0;
  int errors = 0;

  logic [7:0] stg_m[16];
  logic [7:0] act_m[16];
  logic [7:0] dout_m, ioctl_m, st_m;
  bit         lvbl_l_m, armed_m, req_m, queued_m, done_m;

  always #5 clk = ~clk;

  jtshouse_mmr_shadow dut (
    .rst(rst), .clk(clk), .cs(cs), .rnw(rnw), .addr(addr), .din(din), .dout(dout),
    .lvbl(lvbl), .dma_req(dma_req), .dma_ack(dma_ack), .dma_done(dma_done), .regs(regs),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .debug_bus(debug_bus), .st_dout(st_dout)
  );

  jtshouse_mmr_shadow #(.AW(6), .SHADOW(0), .DMA_REG(0)) dut2 (
    .rst(rst), .clk(clk), .cs(cs2), .rnw(rnw2), .addr(addr2), .din(din2), .dout(dout2),
    .lvbl(lvbl2), .dma_req(dma_req2), .dma_ack(dma_ack2), .dma_done(dma_done2), .regs(regs2),
    .ioctl_addr(ioctl_addr2), .ioctl_din(ioctl_din2), .debug_bus(debug_bus2), .st_dout(st_dout2)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] regs_m();
    logic [127:0] r;
    for (int n = 0; n < 16; n++) r[8*n +: 8] = act_m[n];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      stg_m[i] = 8'h00;
      act_m[i] = 8'h00;
    end
    dout_m = 0; ioctl_m = 0; st_m = 0;
    lvbl_l_m = 1; armed_m = 0; req_m = 0; queued_m = 0; done_m = 0;
  endtask

  // One clock: advance the model from the inputs driven now, then compare just after the edge.
  task automatic cyc(input string tag);
    bit fs, wr, dwr;
    fs  = lvbl_l_m && !lvbl;
    wr  = cs && !rnw;
    dwr = wr && (addr == 4'd0);
    dout_m  = stg_m[addr];
    ioctl_m = stg_m[ioctl_addr];
    st_m    = stg_m[debug_bus[3:0]];
    if (fs) for (int i = 0; i < 16; i++) act_m[i] = stg_m[i];
    if (wr) stg_m[addr] = din;
    done_m = 0;
    if (req_m) begin
      if (dma_ack) begin
        req_m = 0; done_m = 1;
        armed_m = queued_m || dwr;
        queued_m = 0;
      end else if (dwr) queued_m = 1;
    end else if (armed_m) begin
      if (fs) begin req_m = 1; armed_m = 0; end
    end else if (dwr) armed_m = 1;
    lvbl_l_m = lvbl;
    @(posedge clk);
    #1;
    chk({tag, ".dout"}, dout, dout_m);
    chk({tag, ".regs"}, regs, regs_m());
    chk({tag, ".dma_req"}, dma_req, req_m);
    chk({tag, ".dma_done"}, dma_done, done_m);
    chk({tag, ".ioctl_din"}, ioctl_din, ioctl_m);
    chk({tag, ".st_dout"}, st_dout, st_m);
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [7:0] d, input string tag);
    cs = 1; rnw = 0; addr = a; din = d;
    cyc(tag);
    cs = 0; rnw = 1;
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst.dout", dout, 8'h00);
    chk("rst.regs", regs, 128'h0);
    chk("rst.dma_req", dma_req, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 0;

    // register write, readback, shadow copy at frame start
    wr_reg(4'd5, 8'h5A, "w5");
    addr = 4'd5;
    cyc("rd5");
    chk("r032.dout", dout, 8'h5A);
    chk("r032.pre", regs[47:40], 8'h00);
    cyc("idle");
    lvbl = 0;
    cyc("fs1");
    chk("r032.post", regs[47:40], 8'h5A);

    // write in the exact fs cycle
    lvbl = 1; cyc("vb1");
    wr_reg(4'd2, 8'h11, "w2a");
    lvbl = 0; cyc("fs2a");
    lvbl = 1; cyc("vb2");
    lvbl = 0; cs = 1; rnw = 0; addr = 4'd2; din = 8'h33;
    cyc("fs2w");
    cs = 0; rnw = 1;
    chk("r033.old", regs[23:16], 8'h11);
    lvbl = 1; cyc("vb3");
    lvbl = 0; cyc("fs3");
    chk("r033.new", regs[23:16], 8'h33);

    // single DMA request held until ack
    lvbl = 1;
    wr_reg(4'd0, 8'h01, "dma_w");
    lvbl = 0; cyc("dma_fs");
    chk("r034.req", dma_req, 1'b1);
    for (int i = 0; i < 10; i++) cyc("dma_hold");
    chk("r034.hold", dma_req, 1'b1);
    dma_ack = 1; cyc("dma_ack");
    dma_ack = 0;
    chk("r034.done", dma_done, 1'b1);
    chk("r034.drop", dma_req, 1'b0);
    cyc("dma_after");
    chk("r034.pulse", dma_done, 1'b0);

    // queued request during REQ
    lvbl = 1;
    wr_reg(4'd0, 8'h02, "q_arm");
    lvbl = 0; cyc("q_fs");
    lvbl = 1;
    wr_reg(4'd0, 8'h03, "q_w1");
    wr_reg(4'd0, 8'h04, "q_w2");
    dma_ack = 1; cyc("q_ack");
    dma_ack = 0;
    cyc("q_wait");
    chk("r035.noreq", dma_req, 1'b0);
    lvbl = 0; cyc("q_fs2");
    chk("r035.req2", dma_req, 1'b1);
    dma_ack = 1; cyc("q_ack2");
    dma_ack = 0; lvbl = 1; cyc("q_vb");
    lvbl = 0; cyc("q_fs3");
    chk("r035.idle", dma_req, 1'b0);

    // reset during REQ
    lvbl = 1;
    wr_reg(4'd0, 8'h05, "r_arm");
    lvbl = 0; cyc("r_fs");
    #2;
    rst = 1;
    #1;
    model_reset();
    chk("r036.req", dma_req, 1'b0);
    chk("r036.regs", regs, 128'h0);
    chk("r036.dout", dout, 8'h00);
    lvbl = 1;
    @(negedge clk); @(negedge clk);
    rst = 0;
    lvbl = 0; cyc("r_fs2");
    lvbl = 1; cyc("r_vb");
    lvbl = 0; cyc("r_fs3");
    chk("r036.noreq", dma_req, 1'b0);

    // AW=6, SHADOW=0 instance
    cs2 = 1; rnw2 = 0; addr2 = 6'd63; din2 = 8'hC3;
    cyc("a6_w");
    chk("r037.regs", regs2[511:504], 8'hC3);
    addr2 = 6'd0; din2 = 8'h7E;
    cyc("a6_w0");
    cs2 = 0; rnw2 = 1; ioctl_addr2 = 6'd63;
    cyc("a6_rd");
    chk("r037.ioctl", ioctl_din2, 8'hC3);
    chk("r037.alias", regs2[511:504], 8'hC3);
    chk("r037.reg0", regs2[7:0], 8'h7E);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cs = 1'($urandom);
      rnw = 1'($urandom);
      addr = 4'($urandom);
      din = 8'($urandom);
      ioctl_addr = 4'($urandom);
      debug_bus = 8'($urandom);
      if ($urandom_range(0, 7) == 0) lvbl = ~lvbl;
      dma_ack = ($urandom_range(0, 5) == 0);
      cyc("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtshouse_mmr_shadow.md
JTSHOUSE_MMR_SHADOW -- requirements
Module: jtshouse_mmr_shadow

Interface
REQ-001 SHALL have parameter AW, default 4, meaning address width; register count SIZE = 2**AW; legal AW 2..6.
REQ-002 SHALL have parameter SHADOW, default 1, meaning 1 = active copy updated only at frame start, 0 = active copy follows staging directly.
REQ-003 SHALL have parameter DMA_REG, default 0, meaning the index of the register whose CPU write arms an object DMA.
REQ-004 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: clk  in  1  clock; all state changes on its rising edge.
REQ-006 SHALL have ports: cs in 1 select; rnw in 1 read-not-write; addr in AW register index; din in 8 write data; dout out 8 read data.
REQ-007 SHALL have port: lvbl  in  1  vertical blank, active low; frame start is its 1->0 transition.
REQ-008 SHALL have ports: dma_req out 1 DMA request, level; dma_ack in 1 DMA complete, one-cycle pulse; dma_done out 1 one-cycle completion pulse.
REQ-009 SHALL have port: regs  out  8*SIZE  active register copy, register n at bits [8n+7:8n].
REQ-010 SHALL have ports: ioctl_addr in AW, ioctl_din out 8, debug_bus in 8, st_dout out 8.

Function
REQ-011 SHALL hold a staging array stg[0:SIZE-1] and an active array act[0:SIZE-1], 8 bits each.
REQ-012 SHALL write din to stg[addr] on a cycle where cs=1 and rnw=0.
REQ-013 SHALL register dout <= stg[addr] every cycle, giving 1-cycle read latency independent of cs; a same-cycle write shows on dout one cycle later.
REQ-014 SHALL register ioctl_din <= stg[ioctl_addr] and st_dout <= stg[debug_bus[AW-1:0]] every cycle.
REQ-015 SHALL detect frame start with a registered copy of lvbl: fs = lvbl_l & ~lvbl, where lvbl_l is lvbl sampled the previous cycle.
REQ-016 SHALL, with SHADOW=1, copy every stg entry into act in the cycle fs=1, so the act update is visible on regs one cycle after fs.
REQ-017 SHALL, on a CPU write coinciding with fs, copy the pre-write staging value into act; the new value reaches act at the next frame start.
REQ-018 SHALL, with SHADOW=0, update act[addr] in the same cycle as stg[addr], so both show the written value one cycle after the write.
REQ-019 SHALL implement the DMA FSM states IDLE, ARMED, REQ.
REQ-020 IDLE: a write to DMA_REG SHALL move the FSM to ARMED.
REQ-021 ARMED: fs SHALL move the FSM to REQ with dma_req=1; further DMA_REG writes SHALL have no effect.
REQ-022 A DMA_REG write in the same cycle as fs while in IDLE SHALL go to ARMED only; the request is issued at the following frame start.
REQ-023 REQ: dma_req SHALL stay 1 until dma_ack=1; on dma_ack, dma_req SHALL go to 0 and dma_done SHALL pulse for exactly one cycle.
REQ-024 A DMA_REG write during REQ SHALL set a queue bit; on dma_ack with the queue bit set, the FSM SHALL go to ARMED and clear the queue bit, otherwise to IDLE.
REQ-025 A write to DMA_REG during REQ in the same cycle as dma_ack SHALL be queued, leading to ARMED.
REQ-026 dma_ack outside REQ SHALL be ignored.
REQ-027 An fs occurring during REQ SHALL not restart or extend the request.
REQ-028 Reads (rnw=1) SHALL never modify state or arm DMA.
REQ-029 Address decoding SHALL be exact over 2**AW entries with no aliasing beyond AW bits.

Reset
REQ-030 On rst=1, SHALL asynchronously clear stg, act, dout, ioctl_din, st_dout, dma_req, dma_done, and the queue bit, set lvbl_l=1, and set the FSM to IDLE.
REQ-031 SHALL, when rst is asserted mid-REQ, drop dma_req immediately and leave no pending request after release.

Verification
REQ-032 Write 0x5A to reg 5 with SHADOW=1, lvbl=1 -> dout=0x5A one cycle after the read address is presented; regs[47:40] stays 0x00 until lvbl falls, then becomes 0x5A one cycle after fs.
REQ-033 Write 0x33 to reg 2 in the exact fs cycle, old value 0x11 -> act[2]=0x11 this frame and 0x33 after the next fs.
REQ-034 Write reg 0 (DMA_REG), then lvbl falls -> dma_req=1 the cycle after fs; hold dma_ack low for 10 cycles -> dma_req stays 1; pulse dma_ack -> dma_req=0 and dma_done=1 for one cycle.
REQ-035 Write reg 0 twice during REQ, then ack -> FSM goes to ARMED; exactly one new request at the next fs; then IDLE.
REQ-036 Assert rst during REQ -> dma_req=0, regs=0, and dout=0 within the same cycle; no request after release without a new write.
REQ-037 SHADOW=0 with AW=6: write 0xC3 to reg 63 -> regs[511:504]=0xC3 one cycle later; ioctl_addr=63 -> ioctl_din=0xC3.
